arb_session_requester: RTL and testbench

- Initiator-side client of the 4-way round-robin arbiter; one instance per requester slot.
- Queues session commands in a small FIFO, raises req, waits for grant, then streams a burst of beats downstream.
- Ends each session with a one-cycle session_is_finished, which is the arbiter's cue to rotate priority.
- Its req, grant and session_is_finished pins connect directly to one bit of the arbiter's req/grant buses and its session_is_finished input.

---
 rtl/arb_session_requester.sv | 162 ++++++++++++++++
 tb/tb_arb_session_requester.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_session_requester.sv
// rtl/arb_session_requester.sv - command-queued round-robin arbiter client (optional REQ_TIMEOUT_EN grant-wait timeout)
module arb_session_requester #(
   parameter int DATA_W      = 8,
   parameter int LEN_W       = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_a,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] cmd_base,
   output logic              req,
   input  logic              grant,
   output logic              session_is_finished,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              err_grant_lost,
   output logic              timeout
);

   localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [LEN_W-1:0]  len_mem  [FIFO_DEPTH];
   logic [DATA_W-1:0] base_mem [FIFO_DEPTH];
   logic [PTR_W:0]    wr_ptr, rd_ptr;
   logic              fifo_full, fifo_empty;
   logic              push, pop, load;

   logic [LEN_W-1:0]  beat_cnt;
   logic [DATA_W-1:0] data_r;
   logic              wait_hit;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && !fifo_full;

   // Command storage; contents need no reset since the pointers gate them.
   always_ff @(posedge clk) begin
      if (push) begin
         len_mem[wr_ptr[PTR_W-1:0]]  <= cmd_len;
         base_mem[wr_ptr[PTR_W-1:0]] <= cmd_base;
      end
   end

   // FIFO pointers advance on accepted push and on FSM-driven pop.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

`ifdef REQ_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
   logic [WAIT_W-1:0] wait_cnt;

   assign wait_hit = (state == ST_REQ) && !grant && (wait_cnt == WAIT_W'(TIMEOUT_CYC));

   // Grant-wait counter: zero outside REQ, counts each ungranted REQ cycle.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         wait_cnt <= '0;
      end else if (state != ST_REQ) begin
         wait_cnt <= '0;
      end else if (!grant && !wait_hit) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end
`else
   // No wait limit in this build; the limit parameter only feeds a constant-false term.
   assign wait_hit = 1'b0 & (TIMEOUT_CYC == 0);
`endif

   assign timeout = wait_hit;

   // FSM state register.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state, FIFO pop and session outputs decoded from the registered state.
   always_comb begin
      state_nxt           = state;
      pop                 = 1'b0;
      load                = 1'b0;
      req                 = 1'b0;
      out_valid           = 1'b0;
      session_is_finished = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            req = 1'b1;
            if (grant) begin
               pop       = 1'b1;
               load      = 1'b1;
               state_nxt = ST_XFER;
            end else if (wait_hit) begin
               pop       = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_XFER: begin
            req       = 1'b1;
            out_valid = 1'b1;
            if (out_ready && (beat_cnt == '0)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            session_is_finished = 1'b1;
            state_nxt           = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Beat counter and data register: loaded at grant, stepped on each accepted non-final beat.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         beat_cnt <= '0;
         data_r   <= '0;
      end else if (load) begin
         beat_cnt <= len_mem[rd_ptr[PTR_W-1:0]];
         data_r   <= base_mem[rd_ptr[PTR_W-1:0]];
      end else if ((state == ST_XFER) && out_ready && (beat_cnt != '0)) begin
         beat_cnt <= beat_cnt - LEN_W'(1);
         data_r   <= data_r + DATA_W'(1);
      end
   end

   // Sticky flag: grant withdrawn while a burst is in flight.
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a)                           err_grant_lost <= 1'b0;
      else if ((state == ST_XFER) && !grant) err_grant_lost <= 1'b1;
   end

   assign out_data = data_r;
   assign out_last = (state == ST_XFER) && (beat_cnt == '0);
   assign busy     = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_arb_session_requester.sv
// tb/tb_arb_session_requester.sv - directed self-checking bench for arb_session_requester
module tb_arb_session_requester;

   logic       clk;
   logic       rst_a;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_len;
   logic [7:0] cmd_base;
   logic       req;
   logic       grant;
   logic       session_is_finished;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
   logic       err_grant_lost;
   logic       timeout;

   int n_checks = 0;
   int n_fail   = 0;
   int acc;

   arb_session_requester #(
      .DATA_W(8), .LEN_W(4), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .rst_a(rst_a),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_base(cmd_base),
      .req(req), .grant(grant), .session_is_finished(session_is_finished),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .err_grant_lost(err_grant_lost), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_cmd(input logic [3:0] len, input logic [7:0] base);
      cmd_valid = 1'b1;
      cmd_len   = len;
      cmd_base  = base;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Entered with the DUT in REQ; leaves it one cycle after DONE (IDLE).
   task automatic do_session(input string tag, input logic [7:0] base, input int len);
      logic [7:0] exp_d;
      grant = 1'b1;
      tick();
      for (int i = 0; i <= len; i++) begin
         exp_d = base + 8'(i);
         chk({tag, "_valid"}, out_valid, 1'b1);
         chk({tag, "_data"}, out_data, exp_d);
         chk({tag, "_last"}, out_last, (i == len));
         tick();
      end
      chk({tag, "_sif"}, session_is_finished, 1'b1);
      chk({tag, "_req_done"}, req, 1'b0);
      chk({tag, "_valid_done"}, out_valid, 1'b0);
      grant = 1'b0;
      tick();
      chk({tag, "_sif_off"}, session_is_finished, 1'b0);
      chk({tag, "_req_idle"}, req, 1'b0);
   endtask

   logic [7:0] t2_base [5];
   logic [3:0] t2_len  [5];

   initial begin
      rst_a     = 1'b1;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      cmd_base  = '0;
      grant     = 1'b0;
      out_ready = 1'b1;
      t2_base   = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
      t2_len    = '{4'd1, 4'd0, 4'd2, 4'd0, 4'd0};

      // reset state
      tick();
      chk("rst_req", req, 1'b0);
      chk("rst_sif", session_is_finished, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_last", out_last, 1'b0);
      chk("rst_data", out_data, 8'h00);
      chk("rst_err", err_grant_lost, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      rst_a = 1'b0;
      tick();
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);

      // single command, grant three cycles after req
      push_cmd(4'd2, 8'h10);
      chk("t1_req_n1", req, 1'b0);
      chk("t1_busy", busy, 1'b1);
      tick();
      chk("t1_req_n2", req, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1_req_hold", req, 1'b1);
         chk("t1_novalid", out_valid, 1'b0);
      end
      do_session("t1", 8'h10, 2);
      chk("t1_busy_end", busy, 1'b0);
      chk("t1_err", err_grant_lost, 1'b0);

      // five pushes into a four-deep FIFO with grant withheld
      for (int k = 0; k < 5; k++) begin
         chk("t2_ready", cmd_ready, (k < 4));
         push_cmd(t2_len[k], t2_base[k]);
      end
      chk("t2_full", cmd_ready, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t2_wait_req", req, 1'b1);
         chk("t2_no_timeout", timeout, 1'b0);
      end
      for (int s = 0; s < 4; s++) begin
         chk("t2_req_on", req, 1'b1);
         do_session("t2", t2_base[s], int'(t2_len[s]));
         chk("t2_ready_after", cmd_ready, 1'b1);
         tick();
         chk("t2_req_gap2", req, (s < 3));
      end
      chk("t2_busy_end", busy, 1'b0);

      // wrapping data with out_ready toggling
      push_cmd(4'd3, 8'hFE);
      tick();
      chk("t3_req", req, 1'b1);
      acc   = 0;
      grant = 1'b1;
      tick();
      chk("t3_d0", out_data, 8'hFE);
      if (out_valid && out_ready) acc++;
      tick();
      chk("t3_d1", out_data, 8'hFF);
      out_ready = 1'b0;
      tick();
      chk("t3_d1_hold", out_data, 8'hFF);
      chk("t3_last_hold0", out_last, 1'b0);
      out_ready = 1'b1;
      if (out_valid && out_ready) acc++;
      tick();
      chk("t3_d2", out_data, 8'h00);
      out_ready = 1'b0;
      tick();
      chk("t3_d2_hold", out_data, 8'h00);
      out_ready = 1'b1;
      if (out_valid && out_ready) acc++;
      tick();
      chk("t3_d3", out_data, 8'h01);
      chk("t3_last", out_last, 1'b1);
      out_ready = 1'b0;
      tick();
      chk("t3_d3_hold", out_data, 8'h01);
      chk("t3_last_held", out_last, 1'b1);
      chk("t3_valid_held", out_valid, 1'b1);
      out_ready = 1'b1;
      if (out_valid && out_ready) acc++;
      tick();
      chk("t3_beats", acc, 4);
      chk("t3_sif", session_is_finished, 1'b1);
      grant = 1'b0;
      tick();

      // grant dropped during the second beat of a four-beat session
      push_cmd(4'd3, 8'h70);
      tick();
      grant = 1'b1;
      tick();
      chk("t4_d0", out_data, 8'h70);
      tick();
      chk("t4_d1", out_data, 8'h71);
      chk("t4_err_pre", err_grant_lost, 1'b0);
      grant = 1'b0;
      tick();
      chk("t4_err_set", err_grant_lost, 1'b1);
      chk("t4_d2", out_data, 8'h72);
      tick();
      chk("t4_d3", out_data, 8'h73);
      chk("t4_last", out_last, 1'b1);
      tick();
      chk("t4_sif", session_is_finished, 1'b1);
      chk("t4_err_sticky", err_grant_lost, 1'b1);
      tick();
      chk("t4_err_idle", err_grant_lost, 1'b1);

      // asynchronous reset in the middle of a burst, second command queued
      push_cmd(4'd5, 8'h80);
      push_cmd(4'd1, 8'h90);
      chk("t5_req", req, 1'b1);
      grant = 1'b1;
      tick();
      tick();
      chk("t5_d1", out_data, 8'h81);
      #2;
      rst_a = 1'b1;
      #1;
      chk("t5_req0", req, 1'b0);
      chk("t5_valid0", out_valid, 1'b0);
      chk("t5_data0", out_data, 8'h00);
      chk("t5_last0", out_last, 1'b0);
      chk("t5_sif0", session_is_finished, 1'b0);
      chk("t5_err0", err_grant_lost, 1'b0);
      chk("t5_busy0", busy, 1'b0);
      grant = 1'b0;
      #2;
      rst_a = 1'b0;
      tick();
      chk("t5_post_busy", busy, 1'b0);
      chk("t5_post_req", req, 1'b0);
      chk("t5_post_sif", session_is_finished, 1'b0);
      chk("t5_post_ready", cmd_ready, 1'b1);
      tick();
      chk("t5_post_busy2", busy, 1'b0);
      chk("t5_post_sif2", session_is_finished, 1'b0);

`ifdef REQ_TIMEOUT_EN
      // grant never given: head command dropped after the wait limit
      push_cmd(4'd0, 8'hA0);
      push_cmd(4'd1, 8'hB0);
      chk("t6_req", req, 1'b1);
      begin
         int cyc;
         cyc = 0;
         while (!timeout && cyc < 40) begin
            tick();
            cyc++;
         end
         chk("t6_timeout_seen", timeout, 1'b1);
         chk("t6_timeout_cyc", cyc, 16);
      end
      chk("t6_no_sif", session_is_finished, 1'b0);
      tick();
      chk("t6_req_drop", req, 1'b0);
      chk("t6_pulse_end", timeout, 1'b0);
      chk("t6_no_sif2", session_is_finished, 1'b0);
      tick();
      chk("t6_rereq", req, 1'b1);
      do_session("t6", 8'hB0, 1);
      chk("t6_busy_end", busy, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
